// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and a digit-legality helper for the
// serial BCD adder.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A packed BCD digit is legal only in the range 0..9.
  function automatic logic digit_bad(input logic [BCD_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Single-digit decimal correcting adder: binary add with carry-in, then
// add 6 and raise the digit carry whenever the binary result exceeds 9.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             ci,
  output logic [BCD_W-1:0] s,
  output logic             co
);

  logic [BCD_W:0] bin;

  // Binary sum first; results above 9 (including binary overflow) are corrected.
  always_comb begin
    bin = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, ci};
    s   = bin[BCD_W-1:0];
    co  = 1'b0;
    if (bin > {1'b0, BCD_MAX}) begin
      s  = bin[BCD_W-1:0] + BCD_CORR;
      co = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor. One digit per clock, least
// significant first, through a single shared correcting digit cell.
// Subtraction adds the nines' complement of y with an initial carry of 1,
// so a negative result comes out in tens' complement with cout=0.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   x,
  input  logic [4*DIGITS-1:0]   y,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  done,
  output logic                  err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t            state;
  state_t            next_state;
  logic [4*DIGITS-1:0] xr;
  logic [4*DIGITS-1:0] yr;
  logic              subr;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [BCD_W-1:0]  a_dig;
  logic [BCD_W-1:0]  y_dig;
  logic [BCD_W-1:0]  b_dig;
  logic [BCD_W-1:0]  s_dig;
  logic              co_dig;
  logic              bad;
  logic              accept;
  logic              last;

  assign accept = (state == IDLE) && start;
  assign last   = (idx == LAST);

  // Select the current digit pair; subtract mode feeds the nines' complement of y.
  always_comb begin
    a_dig = xr[idx*BCD_W +: BCD_W];
    y_dig = yr[idx*BCD_W +: BCD_W];
    b_dig = subr ? (BCD_MAX - y_dig) : y_dig;
  end

  // Flag any non-decimal digit in the operands being presented for acceptance.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_bad(x[i*BCD_W +: BCD_W]) || digit_bad(y[i*BCD_W +: BCD_W])) begin
        bad = 1'b1;
      end
    end
  end

  bcd_digit_cell u_cell (
    .a  (a_dig),
    .b  (b_dig),
    .ci (carry),
    .s  (s_dig),
    .co (co_dig)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for DIGITS cycles, one DONE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: latch operands on acceptance, then write one result digit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr    <= '0;
      yr    <= '0;
      subr  <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      xr    <= x;
      yr    <= y;
      subr  <= sub;
      carry <= sub | cin;
      idx   <= '0;
      err   <= bad;
    end else if (state == RUN) begin
      sum[idx*BCD_W +: BCD_W] <= s_dig;
      carry <= co_dig;
      idx   <= idx + 1'b1;
      if (last) cout <= co_dig;
    end
  end

endmodule
